instr_encoder: RTL and testbench

- Builds 32-bit MIPS machine words from symbolic instruction requests and writes them, in order, into instruction memory.
- It is the writer for the instruction memory that the CPU fetch/decode path reads. It loads test programs and self-check sequences without a precompiled hex file.
- Supports exactly the opcode/funct set the CPU control decodes: R-type ADD/SUB/AND/OR/SLT, plus ADDI, BEQ, BNE, ORI and LUI.

---
 rtl/instr_encoder_if.sv | 45 ++++
 rtl/instr_encoder.sv | 207 ++++++++++++++++++++
 tb/tb_instr_encoder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
//
// Purpose:
//   Bundles the symbolic-instruction request channel and the instruction-memory
//   write channel of instr_encoder into one interface.
//
// Signals:
//   req_valid  request present                 (master -> slave)
//   req_ready  encoder accepts this cycle      (slave  -> master)
//   kind       instruction kind, 0-9 legal     (master -> slave)
//   rs, rt, rd register fields                 (master -> slave)
//   imm        immediate / word branch offset  (master -> slave)
//   mem_we     instruction-memory write strobe (slave  -> master)
//   mem_addr   byte address of the write       (slave  -> master)
//   mem_data   encoded 32-bit machine word     (slave  -> master)
//
// Modports:
//   master : the program loader that issues requests and observes the writes.
//   slave  : the encoder itself.
// -----------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        kind;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;

    modport master (
        output req_valid, kind, rs, rt, rd, imm,
        input  req_ready, mem_we, mem_addr, mem_data
    );

    modport slave (
        input  req_valid, kind, rs, rt, rd, imm,
        output req_ready, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Purpose:
//   Turns symbolic MIPS instruction requests into 32-bit machine words and
//   writes them, in order, into instruction memory starting at BASE_ADDR.
//   Supports R-type ADD/SUB/AND/OR/SLT and ADDI, BEQ, BNE, ORI, LUI. Up to
//   DEPTH words are written per program; start_i re-arms for a new program.
//
// Parameters:
//   ADDR_W     width of the byte address on the memory write port
//   BASE_ADDR  byte address of the first word written after start_i
//   DEPTH      maximum words per program (>= 1)
//
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    asynchronous, active-low reset
//   start_i  one-cycle pulse, arms a new program (pointer, count, error cleared)
//   bus      request channel + memory write channel (slave side)
//   count_o  words written since the last start_i
//   full_o   DEPTH words written; further requests stall until start_i
//   err_o    sticky: an illegal kind (10-15) was accepted
//
// Timing:
//   A legal request accepted on edge N produces mem_we=1 with address and
//   data for the whole cycle after edge N. One word per cycle throughput.
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    instr_encoder_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       err_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    // Kind codes presented on bus.kind; 10-15 are illegal.
    typedef enum logic [3:0] {
        K_ADD  = 4'd0,
        K_SUB  = 4'd1,
        K_AND  = 4'd2,
        K_OR   = 4'd3,
        K_SLT  = 4'd4,
        K_ADDI = 4'd5,
        K_BEQ  = 4'd6,
        K_BNE  = 4'd7,
        K_ORI  = 4'd8,
        K_LUI  = 4'd9
    } kind_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2
    } state_e;

    // Opcodes and R-type function codes understood by the CPU control.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    function automatic logic [31:0] r_type(input logic [5:0] funct,
                                           input logic [4:0] rs,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0]  op,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // -------------------------------------------------------------------------
    // Combinational encoder for the request currently on the bus.
    // -------------------------------------------------------------------------
    logic [31:0] enc_word;
    logic        enc_legal;

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a signal
        // unassigned and no latch is inferred.
        enc_word  = '0;
        enc_legal = 1'b1;
        case (bus.kind)
            K_ADD:   enc_word = r_type(FN_ADD, bus.rs, bus.rt, bus.rd);
            K_SUB:   enc_word = r_type(FN_SUB, bus.rs, bus.rt, bus.rd);
            K_AND:   enc_word = r_type(FN_AND, bus.rs, bus.rt, bus.rd);
            K_OR:    enc_word = r_type(FN_OR,  bus.rs, bus.rt, bus.rd);
            K_SLT:   enc_word = r_type(FN_SLT, bus.rs, bus.rt, bus.rd);
            K_ADDI:  enc_word = i_type(OP_ADDI, bus.rs, bus.rt, bus.imm);
            K_BEQ:   enc_word = i_type(OP_BEQ,  bus.rs, bus.rt, bus.imm);
            K_BNE:   enc_word = i_type(OP_BNE,  bus.rs, bus.rt, bus.imm);
            K_ORI:   enc_word = i_type(OP_ORI,  bus.rs, bus.rt, bus.imm);
            // LUI has no source register; rs is forced to zero.
            K_LUI:   enc_word = i_type(OP_LUI,  5'd0,   bus.rt, bus.imm);
            default: enc_legal = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs.
    // -------------------------------------------------------------------------
    state_e            state;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  count;
    logic              req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              full;
    logic              err;

    // req_ready is only ever 1 in S_RUN, so it doubles as the accept qualifier.
    logic accept;
    assign accept = bus.req_valid && req_ready;

    // The word being accepted is the last one the program may hold.
    logic last_word;
    assign last_word = (count == CNT_W'(DEPTH - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            // NOTE: state is updated with non-blocking assignments only, so
            // every right-hand side below sees the pre-edge values.
            state     <= S_IDLE;
            ptr       <= BASE_ADDR;
            count     <= '0;
            req_ready <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_data  <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // The strobe is a one-cycle pulse unless a new word is written.
            mem_we <= 1'b0;

            if (start_i) begin
                // Re-arm from any state; a request handshaking now is dropped.
                state     <= S_RUN;
                ptr       <= BASE_ADDR;
                count     <= '0;
                req_ready <= 1'b1;
                full      <= 1'b0;
                err       <= 1'b0;
            end else begin
                case (state)
                    S_RUN: begin
                        if (accept) begin
                            if (enc_legal) begin
                                mem_we   <= 1'b1;
                                mem_addr <= ptr;
                                mem_data <= enc_word;
                                // Wraps modulo 2^ADDR_W without complaint.
                                ptr      <= ptr + ADDR_W'(4);
                                count    <= count + CNT_W'(1);
                                if (last_word) begin
                                    state     <= S_FULL;
                                    req_ready <= 1'b0;
                                    full      <= 1'b1;
                                end
                            end else begin
                                // Illegal kinds are consumed without a write.
                                err <= 1'b1;
                            end
                        end
                    end
                    S_IDLE, S_FULL: begin
                        req_ready <= 1'b0;
                    end
                    default: begin
                        state     <= S_IDLE;
                        req_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_data  = mem_data;
    assign count_o       = count;
    assign full_o        = full;
    assign err_o         = err;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder (DEPTH=4, BASE_ADDR=0, ADDR_W=32).
// Directed steps follow the documented scenarios, then a randomized phase is
// compared cycle by cycle against a behavioural model that tracks the program
// as a word counter, a byte pointer and the last write.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 4;
    localparam int          CNT_W  = $clog2(DEPTH + 1);
    localparam logic [31:0] BASE   = 32'h0;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             start_i = 1'b0;
    logic [CNT_W-1:0] count_o;
    logic             full_o;
    logic             err_o;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .bus     (bus),
        .count_o (count_o),
        .full_o  (full_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural reference model
    // ---------------------------------------------------------------------
    bit          m_armed;   // accepting requests
    int          m_words;   // words written in this program
    bit          m_err;
    bit          m_full;
    bit          m_we;
    logic [31:0] m_ptr;
    logic [31:0] m_addr;
    logic [31:0] m_data;

    function automatic logic [31:0] ref_enc(input int kind, input int rs, input int rt,
                                            input int rd, input int imm);
        int functs[5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
        int ops[4]    = '{32'h08, 32'h04, 32'h05, 32'h0D};
        if (kind < 5)
            return 32'(rs * (2 ** 21) + rt * (2 ** 16) + rd * (2 ** 11) + functs[kind]);
        else if (kind < 9)
            return 32'(ops[kind - 5] * (2 ** 26) + rs * (2 ** 21) + rt * (2 ** 16) + imm);
        else
            return 32'(15 * (2 ** 26) + rt * (2 ** 16) + imm);
    endfunction

    task automatic model_reset();
        m_armed = 0; m_words = 0; m_err = 0; m_full = 0; m_we = 0;
        m_ptr = BASE; m_addr = BASE; m_data = 32'h0;
    endtask

    // Applies the inputs currently driven to the model, as the next edge will.
    task automatic model_edge();
        m_we = 0;
        if (start_i) begin
            m_armed = 1; m_words = 0; m_err = 0; m_full = 0; m_ptr = BASE;
        end else if (m_armed && bus.req_valid) begin
            if (int'(bus.kind) <= 9) begin
                m_we    = 1;
                m_addr  = m_ptr;
                m_data  = ref_enc(int'(bus.kind), int'(bus.rs), int'(bus.rt),
                                  int'(bus.rd), int'(bus.imm));
                m_ptr   = m_ptr + 32'd4;
                m_words = m_words + 1;
                if (m_words == DEPTH) begin
                    m_armed = 0;
                    m_full  = 1;
                end
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic compare_all(input string ph);
        check({ph, ".we"},    32'(bus.mem_we),    32'(m_we));
        check({ph, ".addr"},  bus.mem_addr,       m_addr);
        check({ph, ".data"},  bus.mem_data,       m_data);
        check({ph, ".ready"}, 32'(bus.req_ready), 32'(m_armed));
        check({ph, ".count"}, 32'(count_o),       32'(m_words));
        check({ph, ".full"},  32'(full_o),        32'(m_full));
        check({ph, ".err"},   32'(err_o),         32'(m_err));
    endtask

    // One clock: model advances, DUT advances, outputs compared 1 ns later.
    task automatic step(input string ph);
        model_edge();
        @(posedge clk_i);
        #1;
        compare_all(ph);
    endtask

    task automatic set_req(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [15:0] imm);
        bus.req_valid = 1'b1;
        bus.kind = kind; bus.rs = rs; bus.rt = rt; bus.rd = rd; bus.imm = imm;
    endtask

    task automatic pulse_start(input string ph);
        start_i = 1'b1;
        step(ph);
        start_i = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.kind = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.imm = '0;
        model_reset();

        // ---- Reset values ----
        #12;
        check("rst.ready", 32'(bus.req_ready), 32'h0);
        check("rst.we",    32'(bus.mem_we),    32'h0);
        check("rst.addr",  bus.mem_addr,       BASE);
        check("rst.data",  bus.mem_data,       32'h0);
        check("rst.count", 32'(count_o),       32'h0);
        check("rst.full",  32'(full_o),        32'h0);
        check("rst.err",   32'(err_o),         32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        step("idle");

        // ---- Single ADD ----
        pulse_start("t1.start");
        set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
        step("t1.add");
        check("t1.add.lit", bus.mem_data, 32'h00221820);
        bus.req_valid = 1'b0;
        step("t1.idle");

        // ---- Back-to-back ADDI, BEQ, LUI ----
        pulse_start("t2.start");
        set_req(4'd5, 5'd0, 5'd1, 5'd0, 16'h0005);
        step("t2.addi");
        check("t2.addi.lit", bus.mem_data, 32'h20010005);
        set_req(4'd6, 5'd1, 5'd2, 5'd0, 16'hFFFF);
        step("t2.beq");
        check("t2.beq.lit", bus.mem_data, 32'h1022FFFF);
        check("t2.beq.addr", bus.mem_addr, 32'h4);
        set_req(4'd9, 5'd7, 5'd4, 5'd0, 16'h1234);
        step("t2.lui");
        check("t2.lui.lit", bus.mem_data, 32'h3C041234);
        check("t2.lui.addr", bus.mem_addr, 32'h8);
        bus.req_valid = 1'b0;
        step("t2.idle");

        // ---- ORI, illegal kind, SUB ----
        pulse_start("t3.start");
        set_req(4'd8, 5'd4, 5'd4, 5'd0, 16'h5678);
        step("t3.ori");
        check("t3.ori.lit", bus.mem_data, 32'h34845678);
        set_req(4'd12, 5'd9, 5'd9, 5'd9, 16'h9999);
        step("t3.ill");
        check("t3.ill.we", 32'(bus.mem_we), 32'h0);
        check("t3.ill.err", 32'(err_o), 32'h1);
        set_req(4'd1, 5'd5, 5'd6, 5'd5, 16'h0);
        step("t3.sub");
        check("t3.sub.lit", bus.mem_data, 32'h00A62822);
        check("t3.sub.addr", bus.mem_addr, 32'h4);
        check("t3.sub.count", 32'(count_o), 32'h2);
        bus.req_valid = 1'b0;
        step("t3.idle");

        // ---- Fill to DEPTH with valid held, then restart ----
        pulse_start("t4.start");
        set_req(4'd3, 5'd1, 5'd2, 5'd3, 16'h0);
        for (int i = 0; i < DEPTH; i++) step("t4.fill");
        check("t4.last.we",    32'(bus.mem_we),    32'h1);
        check("t4.last.addr",  bus.mem_addr,       32'hC);
        check("t4.last.ready", 32'(bus.req_ready), 32'h0);
        check("t4.last.full",  32'(full_o),        32'h1);
        step("t4.stall");
        step("t4.stall");
        check("t4.stall.we", 32'(bus.mem_we), 32'h0);
        pulse_start("t4.restart");
        check("t4.restart.count", 32'(count_o), 32'h0);
        step("t4.again");
        check("t4.again.addr", bus.mem_addr, BASE);
        bus.req_valid = 1'b0;
        step("t4.idle");

        // ---- start_i mid-program clears pointer and error ----
        pulse_start("t5.start");
        set_req(4'd2, 5'd3, 5'd3, 5'd3, 16'h0);
        step("t5.w0");
        step("t5.w1");
        set_req(4'd15, 5'd0, 5'd0, 5'd0, 16'h0);
        step("t5.ill");
        set_req(4'd4, 5'd8, 5'd9, 5'd10, 16'h0);
        start_i = 1'b1;
        step("t5.restart");
        start_i = 1'b0;
        check("t5.restart.err", 32'(err_o), 32'h0);
        step("t5.w");
        check("t5.w.addr", bus.mem_addr, BASE);
        check("t5.w.we", 32'(bus.mem_we), 32'h1);
        bus.req_valid = 1'b0;
        step("t5.idle");

        // ---- Randomized traffic against the model ----
        for (int n = 0; n < 600; n++) begin
            start_i = ($urandom_range(0, 29) == 0);
            if (!(bus.req_valid && !bus.req_ready)) begin
                bus.req_valid = ($urandom_range(0, 3) != 0);
                bus.kind = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                        : 4'($urandom_range(0, 9));
                bus.rs  = 5'($urandom);
                bus.rt  = 5'($urandom);
                bus.rd  = 5'($urandom);
                bus.imm = 16'($urandom);
            end
            step("rnd");
        end
        start_i = 1'b0;

        // ---- Asynchronous reset while a write is pending ----
        pulse_start("t6.start");
        set_req(4'd0, 5'd1, 5'd1, 5'd1, 16'h0);
        step("t6.w");
        check("t6.w.we", 32'(bus.mem_we), 32'h1);
        #3;
        rst_i = 1'b0;
        #1;
        check("t6.rst.we",    32'(bus.mem_we),    32'h0);
        check("t6.rst.ready", 32'(bus.req_ready), 32'h0);
        check("t6.rst.count", 32'(count_o),       32'h0);
        bus.req_valid = 1'b0;
        model_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        step("t6.post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
